// File: rtl/phase_comp_pkg.sv
// Shared types, constants and clamp arithmetic for the phase-compensator control array.
package phase_comp_pkg;

  localparam logic        DIR_UP  = 1'b0;
  localparam logic        DIR_DN  = 1'b1;
  localparam int unsigned PC_MAXW = 32;
  localparam int unsigned PC_SW   = PC_MAXW + 1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Raw add/sub one bit wider than the accumulator; any bit at or above w means out of range.
  function automatic logic [PC_SW-1:0] raw_addsub(input logic [PC_MAXW-1:0] acc,
                                                   input logic [PC_MAXW-1:0] step,
                                                   input logic               dir);
    return (dir == DIR_DN) ? ({1'b0, acc} - {1'b0, step}) : ({1'b0, acc} + {1'b0, step});
  endfunction

  function automatic logic clamp_hit(input logic [PC_MAXW-1:0] acc,
                                     input logic [PC_MAXW-1:0] step,
                                     input logic               dir,
                                     input int unsigned        w);
    return |(raw_addsub(acc, step, dir) >> w);
  endfunction

  function automatic logic [PC_MAXW-1:0] clamp_addsub(input logic [PC_MAXW-1:0] acc,
                                                       input logic [PC_MAXW-1:0] step,
                                                       input logic               dir,
                                                       input int unsigned        w);
    logic [PC_SW-1:0] sum;
    logic [PC_SW-1:0] top;
    sum = raw_addsub(acc, step, dir);
    top = (PC_SW'(1) << w) - PC_SW'(1);
    if (clamp_hit(acc, step, dir, w))
      return (dir == DIR_DN) ? '0 : PC_MAXW'(top);
    return PC_MAXW'(sum);
  endfunction

endpackage

// File: rtl/phase_comp_sat_addsub.sv
// Shared combinational saturating step datapath used by whichever channel owns the slot.
module phase_comp_sat_addsub
  import phase_comp_pkg::*;
#(
  parameter int unsigned W     = 10,
  parameter int unsigned STEPW = 3
) (
  input  logic [W-1:0]     i_acc,
  input  logic [STEPW-1:0] i_step,
  input  logic             i_dir,
  output logic [W-1:0]     o_nxt_c,
  output logic             o_clamped_c
);

  assign o_nxt_c     = W'(clamp_addsub(PC_MAXW'(i_acc), PC_MAXW'(i_step), i_dir, W));
  assign o_clamped_c = clamp_hit(PC_MAXW'(i_acc), PC_MAXW'(i_step), i_dir, W);

endmodule

// File: rtl/phase_comp_ctrl_array.sv
// Bank of bang-bang phase-compensator accumulators, time-shared over one clamp datapath
// by a round-robin slot pointer, with register load/readback and per-channel lock detect.
module phase_comp_ctrl_array
  import phase_comp_pkg::*;
#(
  parameter int unsigned NCH      = 16,
  parameter int unsigned W        = 10,
  parameter int unsigned OUTW     = 7,
  parameter int unsigned STEPW    = 3,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned RST_VAL  = 512,
  parameter int unsigned CW       = idx_width(NCH)
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                enable,
  input  logic [NCH-1:0]      pd_in,
  input  logic [NCH-1:0]      freeze,
  input  logic [STEPW-1:0]    step,
  input  logic                reg_write_readb,
  input  logic [CW-1:0]       reg_num,
  input  logic [W-1:0]        reg_load_data,
  output logic [W-1:0]        reg_read_data,
  output logic [NCH*OUTW-1:0] ctrl_out,
  output logic [NCH-1:0]      sat,
  output logic [NCH-1:0]      lock
);

  localparam int unsigned AW = idx_width(LOCK_CNT + 1);

  logic [NCH-1:0] r_pd_q;
  logic [CW-1:0]  r_ptr;
  logic [W-1:0]   r_rd;
  logic [W-1:0]   w_acc [NCH];
  logic [W-1:0]   w_nxt;
  logic           w_clamped;
  logic           w_dir;
  logic           w_rd_ok;

  assign w_dir         = r_pd_q[r_ptr];
  assign w_rd_ok       = (32'(reg_num) < NCH);
  assign reg_read_data = r_rd;

  phase_comp_sat_addsub #(
    .W     (W),
    .STEPW (STEPW)
  ) u_addsub (
    .i_acc       (w_acc[r_ptr]),
    .i_step      (step),
    .i_dir       (w_dir),
    .o_nxt_c     (w_nxt),
    .o_clamped_c (w_clamped)
  );

  // Slot pointer wraps at NCH-1 explicitly so non-power-of-two banks sweep correctly.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_ptr  <= '0;
      r_pd_q <= '0;
      r_rd   <= '0;
    end else begin
      r_pd_q <= pd_in;
      if (enable)
        r_ptr <= (r_ptr == CW'(NCH - 1)) ? '0 : r_ptr + CW'(1);
      r_rd <= w_rd_ok ? w_acc[reg_num] : '0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0]  r_acc;
    logic [AW-1:0] r_alt;
    logic          r_last_dir;
    logic          r_sat;
    logic          r_lock;
    logic          w_wr;
    logic          w_upd;

    assign w_wr  = reg_write_readb && (reg_num == CW'(c));
    assign w_upd = enable && !freeze[c] && (r_ptr == CW'(c));

    // Register load beats a same-cycle slot update; lock is registered alongside alt count.
    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        r_acc      <= W'(RST_VAL);
        r_alt      <= '0;
        r_last_dir <= DIR_UP;
        r_sat      <= 1'b0;
        r_lock     <= 1'b0;
      end else if (w_wr) begin
        r_acc  <= reg_load_data;
        r_alt  <= '0;
        r_sat  <= 1'b0;
        r_lock <= 1'b0;
      end else if (w_upd) begin
        r_acc      <= w_nxt;
        r_last_dir <= w_dir;
        if (w_clamped) begin
          r_sat  <= 1'b1;
          r_alt  <= '0;
          r_lock <= 1'b0;
        end else if (w_dir != r_last_dir) begin
          r_alt  <= (r_alt == AW'(LOCK_CNT)) ? r_alt : r_alt + AW'(1);
          r_lock <= (r_alt >= AW'(LOCK_CNT - 1));
        end else begin
          r_alt  <= '0;
          r_lock <= 1'b0;
        end
      end
    end

    assign w_acc[c]                 = r_acc;
    assign sat[c]                   = r_sat;
    assign lock[c]                  = r_lock;
    assign ctrl_out[c*OUTW +: OUTW] = r_acc[W-1 -: OUTW];
  end

endmodule

// File: tb/tb_phase_comp_ctrl_array.sv
// Directed self-checking bench for phase_comp_ctrl_array (16-channel main instance plus a
// 12-channel instance for non-power-of-two wrap and out-of-range register access).
module tb_phase_comp_ctrl_array;

  logic        clk = 1'b0;
  logic        resetb;
  logic        enable;
  logic [15:0] pd_in;
  logic [15:0] freeze;
  logic [2:0]  step;
  logic        reg_write_readb;
  logic [3:0]  reg_num;
  logic [9:0]  reg_load_data;

  logic [9:0]   rd;
  logic [111:0] ctrl;
  logic [15:0]  sat;
  logic [15:0]  lock;

  logic [9:0]   rd2;
  logic [83:0]  ctrl2;
  logic [11:0]  sat2;
  logic [11:0]  lock2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  phase_comp_ctrl_array dut (
    .clk             (clk),
    .resetb          (resetb),
    .enable          (enable),
    .pd_in           (pd_in),
    .freeze          (freeze),
    .step            (step),
    .reg_write_readb (reg_write_readb),
    .reg_num         (reg_num),
    .reg_load_data   (reg_load_data),
    .reg_read_data   (rd),
    .ctrl_out        (ctrl),
    .sat             (sat),
    .lock            (lock)
  );

  phase_comp_ctrl_array #(.NCH(12)) dut12 (
    .clk             (clk),
    .resetb          (resetb),
    .enable          (enable),
    .pd_in           (pd_in[11:0]),
    .freeze          (freeze[11:0]),
    .step            (step),
    .reg_write_readb (reg_write_readb),
    .reg_num         (reg_num),
    .reg_load_data   (reg_load_data),
    .reg_read_data   (rd2),
    .ctrl_out        (ctrl2),
    .sat             (sat2),
    .lock            (lock2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int ch, input int exp);
    enable          = 1'b0;
    reg_write_readb = 1'b0;
    reg_num         = 4'(ch);
    tick();
    chk(tag, 128'(rd), 128'(exp));
  endtask

  task automatic wr_ch(input int ch, input int val);
    enable          = 1'b0;
    reg_write_readb = 1'b1;
    reg_num         = 4'(ch);
    reg_load_data   = 10'(val);
    tick();
    reg_write_readb = 1'b0;
  endtask

  function automatic logic [111:0] fill16(input logic [6:0] v);
    logic [111:0] r;
    for (int i = 0; i < 16; i++) r[i*7 +: 7] = v;
    return r;
  endfunction

  function automatic logic [83:0] fill12(input logic [6:0] v);
    logic [83:0] r;
    for (int i = 0; i < 12; i++) r[i*7 +: 7] = v;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb          = 1'b0;
    enable          = 1'b0;
    pd_in           = '0;
    freeze          = '0;
    step            = 3'd1;
    reg_write_readb = 1'b0;
    reg_num         = '0;
    reg_load_data   = '0;
    tick();
    tick();

    chk("rst_ctrl", 128'(ctrl), 128'(fill16(7'd64)));
    chk("rst_sat",  128'(sat),  128'(16'h0000));
    chk("rst_lock", 128'(lock), 128'(16'h0000));
    chk("rst_rd",   128'(rd),   128'(10'd0));
    resetb = 1'b1;

    // Eight sweeps upward at step 1, then one sweep at step 4.
    enable = 1'b1;
    repeat (128) tick();
    chk("acc_ctrl", 128'(ctrl), 128'(fill16(7'd65)));
    rd_chk("acc_rd0", 0, 520);
    rd_chk("acc_rd15", 15, 520);
    step   = 3'd4;
    enable = 1'b1;
    repeat (16) tick();
    rd_chk("acc_step4", 9, 524);
    chk("acc_lock", 128'(lock), 128'(16'h0000));

    // Upper clamp on channel 3, sticky flag, cleared by write.
    wr_ch(3, 1022);
    enable = 1'b1;
    repeat (3) tick();
    chk("sat_pre", 128'(sat), 128'(16'h0000));
    tick();
    chk("sat_hit", 128'(sat), 128'(16'h0008));
    chk("sat_ctrl3", 128'(ctrl[3*7 +: 7]), 128'(7'd127));
    repeat (28) tick();
    rd_chk("sat_hold", 3, 1023);
    chk("sat_sticky", 128'(sat), 128'(16'h0008));
    rd_chk("sat_other", 4, 532);
    wr_ch(3, 512);
    chk("sat_clr", 128'(sat), 128'(16'h0000));

    // Lower clamp on channel 6.
    pd_in = 16'h0040;
    wr_ch(6, 2);
    enable = 1'b1;
    repeat (16) tick();
    rd_chk("sat_low", 6, 0);
    chk("sat_low_flag", 128'(sat), 128'(16'h0040));
    pd_in = '0;
    wr_ch(6, 512);

    // Asynchronous reset mid-sweep, then restart at channel 0.
    enable = 1'b1;
    repeat (5) tick();
    #3 resetb = 1'b0;
    #1;
    chk("mid_rst_ctrl", 128'(ctrl), 128'(fill16(7'd64)));
    chk("mid_rst_sat",  128'(sat),  128'(16'h0000));
    tick();
    resetb = 1'b1;
    step   = 3'd1;
    enable = 1'b1;
    tick();
    rd_chk("restart_ch0", 0, 513);
    rd_chk("restart_ch1", 1, 512);

    // Freeze channel 5 for four sweeps; pointer keeps walking.
    freeze = 16'h0020;
    enable = 1'b1;
    repeat (64) tick();
    rd_chk("frz_ch5", 5, 512);
    rd_chk("frz_ch4", 4, 516);
    rd_chk("frz_ch0", 0, 517);
    freeze = '0;
    enable = 1'b1;
    repeat (5) tick();
    rd_chk("frz_ptr5", 5, 513);
    rd_chk("frz_ptr6", 6, 516);

    // Lock on channel 2: four alternating updates, then a repeat direction.
    enable = 1'b1;
    repeat (10) tick();
    for (int k = 0; k < 4; k++) begin
      pd_in = (k % 2 == 0) ? 16'h0004 : 16'h0000;
      repeat (2) tick();
      chk("lock_pre", 128'(lock), 128'(16'h0000));
      tick();
      chk("lock_upd", 128'(lock), 128'((k == 3) ? 16'h0004 : 16'h0000));
      repeat (13) tick();
    end
    pd_in = '0;
    repeat (2) tick();
    chk("lock_hold", 128'(lock), 128'(16'h0004));
    tick();
    chk("lock_drop", 128'(lock), 128'(16'h0000));

    // Write into the channel currently owning the slot.
    enable          = 1'b1;
    reg_write_readb = 1'b1;
    reg_num         = 4'd3;
    reg_load_data   = 10'd100;
    tick();
    reg_write_readb = 1'b0;
    chk("coll_ctrl3", 128'(ctrl[3*7 +: 7]), 128'(7'd12));
    rd_chk("coll_rd", 3, 100);

    // 12-channel wrap and out-of-range register access.
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    step   = 3'd1;
    enable = 1'b1;
    repeat (24) tick();
    rd_chk("wrap16_ch11", 11, 513);
    chk("wrap12_ch11", 128'(rd2), 128'(10'd514));
    wr_ch(15, 77);
    reg_num = 4'd15;
    tick();
    chk("oor_rd16", 128'(rd),  128'(10'd77));
    chk("oor_rd12", 128'(rd2), 128'(10'd0));
    chk("oor_ctrl12", 128'(ctrl2), 128'(fill12(7'd64)));
    chk("oor_sat12", 128'(sat2), 128'(12'h000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
